// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table and parameter limits for the 7-segment scan driver
// Contents:
//   glyph_t          active-high segment vector, bit 0 = a ... bit 6 = g
//   GLYPH_TABLE      hex glyphs 0-9, A, b, C, d, E, F
//   *_MIN / *_MAX    legal parameter ranges, checked at elaboration by the top
package seg7_pkg;

    localparam int NUM_DIGITS_MIN  = 2;
    localparam int NUM_DIGITS_MAX  = 8;
    localparam int REFRESH_DIV_MIN = 4;

    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data/control inputs and multiplexed display outputs
// Signals:
//   data, dp_in, load, lz_en   driven by the master (host side)
//   seg, dp, an, frame_tick    driven by the slave (scan driver)
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output data, dp_in, load, lz_en,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  data, dp_in, load, lz_en,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high 7-segment glyph
// Ports:
//   nibble_i  in   4  hex value
//   glyph_o   out  7  segments a..g, bit 0 = a
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output glyph_t     glyph_o
);

    assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex display driver with blanking and leading-zero suppression
// Ports:
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous active-low reset
//   bus   slave modport of seg7_scan_driver_if:
//         data/dp_in/load/lz_en in, seg/dp/an/frame_tick out
// Each digit owns REFRESH_DIV cycles; the first BLANK_CYCLES of a slot keep
// every anode (and the segments) dark so the previous digit cannot ghost.
// All outputs are registered one cycle behind the counter/index state.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_driver_if.slave bus
);

    if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS out of range");
    end
    if (REFRESH_DIV < REFRESH_DIV_MIN || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_timing
        $error("seg7_scan_driver: REFRESH_DIV/BLANK_CYCLES out of range");
    end

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   data_q, data_d;
    logic [NUM_DIGITS-1:0]     dpsh_q, dpsh_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    glyph_t                    seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      ft_q, ft_d;

    logic                      terminal;
    logic                      lit;
    logic                      zero_above;
    logic                      suppress;
    logic                      dp_sel;
    logic [3:0]                nibble_sel;
    glyph_t                    glyph;

    // The index mux sits ahead of the decoder so only one decoder is needed.
    seg7_hex_decode u_decode (
        .nibble_i (nibble_sel),
        .glyph_o  (glyph)
    );

    always_comb begin
        terminal = (cnt_q == CNT_LAST);
        cnt_d    = terminal ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        ft_d = terminal && (idx_q == IDX_LAST);

        data_d = bus.load ? bus.data  : data_q;
        dpsh_d = bus.load ? bus.dp_in : dpsh_q;

        // Walk from the most significant digit down: zero_above stays set while
        // every nibble from the top down to digit i is zero, which is exactly
        // the leading-zero condition for digit i. Digit 0 is never blanked.
        nibble_sel = '0;
        dp_sel     = 1'b0;
        suppress   = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (data_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nibble_sel = data_q[4*i +: 4];
                dp_sel     = dpsh_q[i];
                suppress   = bus.lz_en && zero_above && (i != 0);
            end
        end

        lit   = (cnt_q >= CNT_BLANK);
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (lit) begin
            an_d  = AN_ONE << idx_q;
            seg_d = suppress ? '0 : glyph;
            dp_d  = dp_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            dpsh_q <= '0;
            an_q   <= '0;
            seg_q  <= '0;
            dp_q   <= 1'b0;
            ft_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            dpsh_q <= dpsh_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            ft_q   <= ft_d;
        end
    end

    // Polarity is a static inversion after the registers, so the pins stay
    // glitch-free and every internal signal remains active-high.
    assign bus.an         = ACTIVE_LOW ? ~an_q  : an_q;
    assign bus.seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign bus.dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
    assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for two seg7_scan_driver configurations
module tb_seg7_scan_driver;

    localparam int NA = 4, DA = 8, BA = 2;
    localparam bit LA = 1'b1;
    localparam int NB = 8, DB = 4, BB = 1;
    localparam bit LB = 1'b0;

    typedef logic [16:0] obs_t;   // {an[7:0], seg[6:0], dp, frame_tick}

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(NA)) ifa ();
    seg7_scan_driver_if #(.NUM_DIGITS(NB)) ifb ();

    seg7_scan_driver #(.NUM_DIGITS(NA), .REFRESH_DIV(DA), .BLANK_CYCLES(BA), .ACTIVE_LOW(LA))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    seg7_scan_driver #(.NUM_DIGITS(NB), .REFRESH_DIV(DB), .BLANK_CYCLES(BB), .ACTIVE_LOW(LB))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    obs_t        qa [$];
    obs_t        qb [$];
    int          checks = 0;
    int          passed = 0;
    int          k = 0;            // rising edges since reset was released
    logic [15:0] sha = '0;
    logic [3:0]  dpa = '0;
    logic [31:0] shb = '0;
    logic [7:0]  dpb = '0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Outputs after edge kk reflect the scan position reached after edge kk-1.
    function automatic obs_t model(input int n, input int div, input int blank, input bit al,
                                   input int kk, input logic [31:0] d, input logic [7:0] dpv,
                                   input bit lz);
        logic [7:0] an = '0;
        logic [6:0] sg = '0;
        logic       p  = 1'b0;
        logic       ft = 1'b0;
        int         t, c, idx;
        bit         sup;
        if (kk > 0) begin
            t   = kk - 1;
            c   = t % div;
            idx = (t / div) % n;
            ft  = ((kk % (n * div)) == 0);
            if (c >= blank) begin
                an[idx] = 1'b1;
                sup = lz && (idx != 0);
                for (int j = idx; j < n; j++) if (d[4*j +: 4] != 4'h0) sup = 1'b0;
                sg = sup ? 7'h00 : glyph(d[4*idx +: 4]);
                p  = dpv[idx];
            end
        end
        if (al) begin
            for (int i = 0; i < n; i++) an[i] = ~an[i];
            sg = ~sg;
            p  = ~p;
        end
        return {an, sg, p, ft};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s at %0t k=%0d: got an/seg/dp/ft=%h expected %h", name, $time, k, act, req);
    endtask

    task automatic step(input bit ld, input logic [15:0] da, input logic [3:0] pa,
                        input logic [31:0] db, input logic [7:0] pb, input bit lz);
        ifa.load = ld;  ifa.data = da;  ifa.dp_in = pa;  ifa.lz_en = lz;
        ifb.load = ld;  ifb.data = db;  ifb.dp_in = pb;  ifb.lz_en = lz;
        @(posedge clk);
        if (!rst) begin
            k = 0;  sha = '0;  dpa = '0;  shb = '0;  dpb = '0;
        end else begin
            k++;
        end
        qa.push_back(model(NA, DA, BA, LA, k, {16'h0, sha}, {4'h0, dpa}, lz));
        qb.push_back(model(NB, DB, BB, LB, k, shb, dpb, lz));
        if (rst && ld) begin
            sha = da;  dpa = pa;  shb = db;  dpb = pb;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit lz);
        repeat (n) step(1'b0, 16'($urandom), 4'($urandom), $urandom, 8'($urandom), lz);
    endtask

    // Monitor: both drivers present a new output word every cycle.
    initial begin
        obs_t ea, eb;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("scan_a", {4'h0, ifa.an, ifa.seg, ifa.dp, ifa.frame_tick}, ea);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("scan_b", {ifb.an, ifb.seg, ifb.dp, ifb.frame_tick}, eb);
            end
        end
    end

    initial begin
        bit lz_r = 1'b0;
        // reset held for three edges, then released between edges
        repeat (3) step(1'b0, 16'h0, 4'h0, 32'h0, 8'h0, 1'b0);
        rst = 1'b1;

        // basic scan: 1234 on the 4-digit unit, full glyph/dp sweep on the 8-digit unit
        step(1'b1, 16'h1234, 4'h0, 32'hFEDCBA98, 8'h81, 1'b0);
        idle(70, 1'b0);

        // leading zeros with and without suppression
        step(1'b1, 16'h0050, 4'h4, 32'h0000_0050, 8'h40, 1'b1);
        idle(40, 1'b1);
        idle(40, 1'b0);

        // load coincident with the index 0->1 terminal count of the 4-digit unit
        while (((k + 1) % (NA * DA)) != DA) idle(1, 1'b0);
        step(1'b1, 16'hABCD, 4'h2, 32'h0000_ABCD, 8'h02, 1'b0);
        idle(20, 1'b0);

        // randomized traffic with short values to exercise suppression
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) lz_r = ~lz_r;
            step($urandom_range(0, 7) == 0,
                 16'($urandom >> (4 * $urandom_range(0, 3))), 4'($urandom),
                 $urandom >> (4 * $urandom_range(0, 7)), 8'($urandom), lz_r);
        end

        // asynchronous reset in the lit part of a slot, sampled before the next edge
        while ((k % 8) != 6) idle(1, 1'b0);
        #5;
        rst = 1'b0;
        #1;
        check("async_rst_a", {4'h0, ifa.an, ifa.seg, ifa.dp, ifa.frame_tick},
              model(NA, DA, BA, LA, 0, 32'h0, 8'h0, 1'b0));
        check("async_rst_b", {ifb.an, ifb.seg, ifb.dp, ifb.frame_tick},
              model(NB, DB, BB, LB, 0, 32'h0, 8'h0, 1'b0));
        repeat (2) step(1'b0, 16'h0, 4'h0, 32'h0, 8'h0, 1'b0);
        rst = 1'b1;
        idle(40, 1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
